req_gnt_window_checker: RTL
===========================

Name: req_gnt_window_checker

Overview:
- Synthesizable, parametrised request/grant protocol checker.
- Monitors NUM_CH independent req/gnt channels and checks each grant against a programmable latency window [MIN_LAT, MAX_LAT].
- Flags early, late, dropped and spurious grants with per-channel error codes, sticky bits and saturating counters.
- Sits beside the RTL under test in benches and in debug builds; it is passive and never drives req or gnt.

Parameters:
- NUM_CH, 4: number of monitored channels (1..32).
- MIN_LAT, 1: minimum legal request-to-grant latency in cycles (0 allowed).
- MAX_LAT, 4: maximum legal latency; must satisfy MAX_LAT >= MIN_LAT and MAX_LAT <= 255.
- CNT_W, 16: width of the pass and error counters.

Ports:
- clk, input, 1: single clock; everything is sampled on its posedge.
- rst, input, 1: synchronous, active-high reset.
- clr, input, 1: synchronous clear of sticky bits, counters and lat_max; FSMs are not affected.
- req, input, NUM_CH: request per channel.
- gnt, input, NUM_CH: grant per channel.
- err_pulse, output, NUM_CH: one-cycle pulse on the channel that erred.
- err_code, output, 2*NUM_CH: code per channel, valid while err_pulse is high. 0 = EARLY, 1 = TIMEOUT, 2 = DROP, 3 = SPUR.
- err_sticky, output, NUM_CH: set on any error; held until clr or rst.
- pass_cnt, output, CNT_W: count of in-window grants, all channels.
- err_cnt, output, CNT_W: count of error events, all channels.
- lat_max, output, 8: largest in-window latency seen.

Behaviour:
- Reset: rst=1 at a posedge puts every channel FSM in IDLE with age=0. All outputs go to 0, including err_code. Reset mid-transaction discards the transaction with no error.
- Latency L: number of cycles from the acceptance cycle (req first sampled high in IDLE/DONE) to the cycle gnt is sampled high. gnt in the acceptance cycle gives L=0.
- Per-channel FSM states: IDLE, WAIT, DONE, FLUSH. Transitions:
  - IDLE, req=1, gnt=1: evaluate L=0, then go to DONE.
  - IDLE, req=1, gnt=0: go to WAIT with age=1.
  - IDLE, req=0, gnt=1: SPUR, stay in IDLE.
  - WAIT, gnt=1: evaluate L=age, then go to DONE.
  - WAIT, gnt=0, req=0: DROP, go to IDLE.
  - WAIT, gnt=0, req=1, age==MAX_LAT: TIMEOUT, go to FLUSH.
  - WAIT, otherwise: age++.
  - DONE: gnt=1 is SPUR (double grant), go to IDLE. Otherwise behave exactly as IDLE, so back-to-back requests are legal.
  - FLUSH: stay until req=0, then go to IDLE. gnt=1 while in FLUSH is SPUR.
- Evaluation of L:
  - L < MIN_LAT: EARLY.
  - L <= MAX_LAT: pass. Increment pass_cnt and update lat_max = max(lat_max, L).
  - A grant can never arrive with L > MAX_LAT, because TIMEOUT fires first.
- Output timing: err_pulse, err_code, err_sticky and the counters are registered. They update one cycle after the sampling edge that detected the event. An error or pass detected at edge n is visible after edge n+1.
- Simultaneous events:
  - Several channels may err in the same cycle; each drives its own err_pulse bit.
  - err_cnt adds the popcount of errors, and pass_cnt adds the popcount of passes, in one cycle.
  - Both counters saturate at 2^CNT_W-1 and never wrap.
- clr with a same-cycle event: clr wins for sticky bits, counters and lat_max (they go to 0). err_pulse and err_code still report the event.
- age is an 8-bit counter per channel. It never exceeds MAX_LAT.

Decomposition:
- Package req_gnt_chk_pkg holds:
  - chk_state_e (IDLE, WAIT, DONE, FLUSH);
  - err_code_e (EARLY, TIMEOUT, DROP, SPUR);
  - the localparam for the age width.
- Sub-module req_gnt_ch_fsm: one per channel, built with a generate loop. Inputs are req/gnt bits; outputs are pass, err, code and L.
- The top level does popcount accumulation, saturation, lat_max and the registered outputs.

Test Plan:
- Defaults. ch0 req=1 at cycle 10, gnt=1 at cycle 12 (L=2), req=0 at cycle 13 -> pass_cnt=1, lat_max=2, no err_pulse.
- ch1 req and gnt both high in the same cycle (L=0 < MIN_LAT=1) -> err_pulse[1] one cycle later, err_code=EARLY, err_sticky[1]=1, err_cnt=1.
- ch2 req held 5 cycles with no gnt -> TIMEOUT at age 4. gnt on the next cycle -> SPUR. err_cnt=2, and the channel returns to IDLE once req=0.
- ch3 req high 2 cycles, then dropped with no gnt -> DROP. A lone gnt pulse on ch3 with req=0 -> SPUR.
- All 4 channels grant in window on the same cycle -> pass_cnt +4 in one step. With CNT_W=2, passes saturate at 3.
- rst asserted while ch0 is in WAIT, then req re-asserted -> no error from the aborted transaction, fresh L measured. clr pulse -> sticky bits and counters read 0 on the next cycle.

Source files
------------

// File: rtl/req_gnt_chk_pkg.sv
// Shared types for the request/grant window checker: FSM states, error codes
// and the width of the per-channel age counter.
package req_gnt_chk_pkg;
   localparam int AGE_W = 8;

   typedef enum logic [1:0] {IDLE, WAIT, DONE, FLUSH} chk_state_e;
   typedef enum logic [1:0] {
      EARLY   = 2'd0,
      TIMEOUT = 2'd1,
      DROP    = 2'd2,
      SPUR    = 2'd3
   } err_code_e;
endpackage

// File: rtl/req_gnt_window_checker_if.sv
// Request/grant bundle observed by the checker; the checker only listens
// through the slave modport.
interface req_gnt_window_checker_if #(
   parameter int NUM_CH = 4
) ();
   logic [NUM_CH-1:0] req;
   logic [NUM_CH-1:0] gnt;

   modport master (output req, output gnt);
   modport slave  (input req, input gnt);
endinterface

// File: rtl/req_gnt_ch_fsm.sv
// Per-channel request/grant tracker. Decides pass/error for each edge and
// registers the verdict, so results lag the sampling edge by one cycle.
module req_gnt_ch_fsm
   import req_gnt_chk_pkg::*;
#(
   parameter int MIN_LAT = 1,
   parameter int MAX_LAT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req,
   input  logic             gnt,
   output logic             pass,
   output logic             err,
   output err_code_e        code,
   output logic [AGE_W-1:0] lat
);
   localparam logic [AGE_W-1:0] MIN_AGE = AGE_W'(MIN_LAT);
   localparam logic [AGE_W-1:0] MAX_AGE = AGE_W'(MAX_LAT);

   chk_state_e       state, state_nxt;
   logic [AGE_W-1:0] age, age_nxt;
   logic             pass_nxt, err_nxt, do_eval;
   err_code_e        code_nxt;
   logic [AGE_W-1:0] lat_nxt, l_eval;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         age   <= '0;
         pass  <= 1'b0;
         err   <= 1'b0;
         code  <= EARLY;
         lat   <= '0;
      end else begin
         state <= state_nxt;
         age   <= age_nxt;
         pass  <= pass_nxt;
         err   <= err_nxt;
         code  <= code_nxt;
         lat   <= lat_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      age_nxt   = age;
      pass_nxt  = 1'b0;
      err_nxt   = 1'b0;
      code_nxt  = EARLY;
      lat_nxt   = '0;
      do_eval   = 1'b0;
      l_eval    = '0;
      unique case (state)
         WAIT: begin
            if (gnt) begin
               do_eval   = 1'b1;
               l_eval    = age;
               state_nxt = DONE;
               age_nxt   = '0;
            end else if (!req) begin
               err_nxt   = 1'b1;
               code_nxt  = DROP;
               state_nxt = IDLE;
               age_nxt   = '0;
            end else if (age >= MAX_AGE) begin
               err_nxt   = 1'b1;
               code_nxt  = TIMEOUT;
               state_nxt = FLUSH;
               age_nxt   = '0;
            end else begin
               age_nxt = age + 1'b1;
            end
         end
         FLUSH: begin
            if (gnt) begin
               err_nxt  = 1'b1;
               code_nxt = SPUR;
            end
            if (!req) state_nxt = IDLE;
         end
         default: begin
            // DONE only differs from IDLE by treating a repeated grant as spurious
            if (state == DONE && gnt) begin
               err_nxt   = 1'b1;
               code_nxt  = SPUR;
               state_nxt = IDLE;
            end else if (req && gnt) begin
               do_eval   = 1'b1;
               state_nxt = DONE;
            end else if (req) begin
               if (MAX_LAT == 0) begin
                  err_nxt   = 1'b1;
                  code_nxt  = TIMEOUT;
                  state_nxt = FLUSH;
               end else begin
                  state_nxt = WAIT;
                  age_nxt   = AGE_W'(1);
               end
            end else begin
               if (gnt) begin
                  err_nxt  = 1'b1;
                  code_nxt = SPUR;
               end
               state_nxt = IDLE;
            end
         end
      endcase
      if (do_eval) begin
         if (l_eval < MIN_AGE) begin
            err_nxt  = 1'b1;
            code_nxt = EARLY;
         end else begin
            pass_nxt = 1'b1;
            lat_nxt  = l_eval;
         end
      end
   end
endmodule

// File: rtl/req_gnt_window_checker.sv
// Passive multi-channel req/gnt latency-window checker: per-channel FSM
// verdicts are collected into pulses, sticky bits, saturating counters and lat_max.
module req_gnt_window_checker
   import req_gnt_chk_pkg::*;
#(
   parameter int NUM_CH  = 4,
   parameter int MIN_LAT = 1,
   parameter int MAX_LAT = 4,
   parameter int CNT_W   = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr,
   req_gnt_window_checker_if.slave    bus,
   output logic [NUM_CH-1:0]          err_pulse,
   output logic [2*NUM_CH-1:0]        err_code,
   output logic [NUM_CH-1:0]          err_sticky,
   output logic [CNT_W-1:0]           pass_cnt,
   output logic [CNT_W-1:0]           err_cnt,
   output logic [7:0]                 lat_max
);
   logic [NUM_CH-1:0]   pass_p0, err_p0;
   err_code_e           code_p0 [NUM_CH];
   logic [AGE_W-1:0]    lat_p0  [NUM_CH];
   logic [2*NUM_CH-1:0] code_vec_p0;
   logic [AGE_W-1:0]    lat_peak_p0;

   function automatic logic [5:0] popcount(input logic [NUM_CH-1:0] v);
      logic [5:0] n;
      n = '0;
      for (int i = 0; i < NUM_CH; i++) n = n + 6'(v[i]);
      return n;
   endfunction

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [5:0]       b);
      logic [CNT_W+6:0] s;
      s = {7'd0, a} + {{(CNT_W+1){1'b0}}, b};
      if (s > {7'd0, {CNT_W{1'b1}}}) return '1;
      return s[CNT_W-1:0];
   endfunction

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      req_gnt_ch_fsm #(
         .MIN_LAT (MIN_LAT),
         .MAX_LAT (MAX_LAT)
      ) u_fsm (
         .clk  (clk),
         .rst  (rst),
         .req  (bus.req[i]),
         .gnt  (bus.gnt[i]),
         .pass (pass_p0[i]),
         .err  (err_p0[i]),
         .code (code_p0[i]),
         .lat  (lat_p0[i])
      );
   end

   // stage p0 -> outputs: merge per-channel verdicts
   always_comb begin
      code_vec_p0 = '0;
      lat_peak_p0 = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (err_p0[i]) code_vec_p0[2*i +: 2] = code_p0[i];
         if (pass_p0[i] && lat_p0[i] > lat_peak_p0) lat_peak_p0 = lat_p0[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_pulse  <= '0;
         err_code   <= '0;
         err_sticky <= '0;
         pass_cnt   <= '0;
         err_cnt    <= '0;
         lat_max    <= '0;
      end else begin
         err_pulse <= err_p0;
         err_code  <= code_vec_p0;
         if (clr) begin
            err_sticky <= '0;
            pass_cnt   <= '0;
            err_cnt    <= '0;
            lat_max    <= '0;
         end else begin
            err_sticky <= err_sticky | err_p0;
            pass_cnt   <= sat_add(pass_cnt, popcount(pass_p0));
            err_cnt    <= sat_add(err_cnt, popcount(err_p0));
            if (lat_peak_p0 > lat_max) lat_max <= lat_peak_p0;
         end
      end
   end
endmodule
